alu_imm_seq: RTL and testbench

//  Parametrised sequencer for ALU-immediate instructions (Rd <- Rd op imm).
//  - Sits between instruction fetch/decode and the register file / ALU datapath.
//  - Per instruction it:
//    1. drives the selected register onto ALU operand A;
//    2. drives the extended immediate onto operand B;
//    3. runs the ALU for a programmable number of cycles;
//    4. writes the result back to the same register.
//  - Generalises register count, data/immediate width and ALU latency.
//  - Drives no tristate buses and contains no latches.

---
 rtl/alu_imm_seq_if.sv | 35 +++
 rtl/alu_imm_seq.sv | 115 +++++++++++
 tb/tb_alu_imm_seq.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_imm_seq_if.sv
// Bundles the request and datapath-control signals of the ALU-immediate sequencer.
// The sequencer is the slave. Whoever issues instructions is the master.
interface alu_imm_seq_if #(
  parameter int NUM_REGS = 4,
  parameter int SEL_W    = 4,
  parameter int DATA_W   = 16,
  parameter int IMM_W    = 6
);
  logic                start;
  logic                abort;
  logic [SEL_W-1:0]    reg_sel;
  logic [IMM_W-1:0]    imm;
  logic [NUM_REGS-1:0] reg_out_en;
  logic [NUM_REGS-1:0] reg_in_en;
  logic                alu_a_en;
  logic                alu_b_en;
  logic [DATA_W-1:0]   imm_bus;
  logic                alu_op_en;
  logic                alu_out_en;
  logic                busy;
  logic                done;
  logic                err;

  modport master (
    output start, abort, reg_sel, imm,
    input  reg_out_en, reg_in_en, alu_a_en, alu_b_en, imm_bus,
           alu_op_en, alu_out_en, busy, done, err
  );

  modport slave (
    input  start, abort, reg_sel, imm,
    output reg_out_en, reg_in_en, alu_a_en, alu_b_en, imm_bus,
           alu_op_en, alu_out_en, busy, done, err
  );
endinterface

// File: rtl/alu_imm_seq.sv
// Sequencer for ALU-immediate instructions (Rd <- Rd op imm): LOAD_A, LOAD_B, EXEC, WRITE, DONE.
// Define ALUIMM_SIGNEXT_EN to sign-extend the immediate. The default is zero extension.
module alu_imm_seq #(
  parameter int NUM_REGS    = 4,
  parameter int SEL_W       = 4,
  parameter int DATA_W      = 16,
  parameter int IMM_W       = 6,
  parameter int EXEC_CYCLES = 1
) (
  input  logic         clk,
  input  logic         rst,
  alu_imm_seq_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, LOAD_A, LOAD_B, EXEC, WRITE, DONE
  } state_t;

  localparam logic [3:0]     CNT_INIT   = 4'(EXEC_CYCLES - 1);
  localparam logic [SEL_W:0] NREGS_CMP  = (SEL_W + 1)'(NUM_REGS);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [IMM_W-1:0]  imm_q, imm_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] imm_ext;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sel_q   <= '0;
      imm_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      imm_q   <= imm_d;
      err_q   <= err_d;
    end
  end

  // abort outranks everything except rst, including a start seen in IDLE
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    imm_d   = imm_q;
    err_d   = 1'b0;
    if (bus.abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            if ({1'b0, bus.reg_sel} < NREGS_CMP) begin
              sel_d   = bus.reg_sel;
              imm_d   = bus.imm;
              state_d = LOAD_A;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        LOAD_A: state_d = LOAD_B;
        LOAD_B: begin
          cnt_d   = CNT_INIT;
          state_d = EXEC;
        end
        EXEC: begin
          if (cnt_q == 4'd0) begin
            state_d = WRITE;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        WRITE:   state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  generate
    if (IMM_W == DATA_W) begin : g_pass
      assign imm_ext = imm_q;
    end else begin : g_ext
`ifdef ALUIMM_SIGNEXT_EN
      assign imm_ext = {{(DATA_W - IMM_W){imm_q[IMM_W-1]}}, imm_q};
`else
      assign imm_ext = {{(DATA_W - IMM_W){1'b0}}, imm_q};
`endif
    end
  endgenerate

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_en
      assign bus.reg_out_en[gi] = (state_q == LOAD_A) && (sel_q == SEL_W'(gi));
      assign bus.reg_in_en[gi]  = (state_q == WRITE)  && (sel_q == SEL_W'(gi));
    end
  endgenerate

  assign bus.alu_a_en   = (state_q == LOAD_A);
  assign bus.alu_b_en   = (state_q == LOAD_B);
  assign bus.imm_bus    = (state_q == LOAD_B) ? imm_ext : '0;
  assign bus.alu_op_en  = (state_q == EXEC);
  assign bus.alu_out_en = (state_q == WRITE);
  assign bus.busy       = (state_q != IDLE);
  assign bus.done       = (state_q == DONE);
  assign bus.err        = err_q;

endmodule

// File: tb/tb_alu_imm_seq.sv
// Scoreboard bench: directed instructions push the expected per-cycle output snapshots.
// Per-DUT monitors pop and compare whenever any output is active.
module tb_alu_imm_seq;

  logic clk = 1'b0;
  logic rst0, rst1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   mon_en = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_imm_seq_if #(.NUM_REGS(4), .SEL_W(4), .DATA_W(16), .IMM_W(6)) if0 ();
  alu_imm_seq_if #(.NUM_REGS(4), .SEL_W(4), .DATA_W(16), .IMM_W(6)) if1 ();

  alu_imm_seq #(.NUM_REGS(4), .SEL_W(4), .DATA_W(16), .IMM_W(6), .EXEC_CYCLES(1))
    dut0 (.clk(clk), .rst(rst0), .bus(if0.slave));
  alu_imm_seq #(.NUM_REGS(4), .SEL_W(4), .DATA_W(16), .IMM_W(6), .EXEC_CYCLES(3))
    dut1 (.clk(clk), .rst(rst1), .bus(if1.slave));

`ifdef ALUIMM_SIGNEXT_EN
  localparam logic [15:0] EXT_3A = 16'hFFFA;
  localparam logic [15:0] EXT_2A = 16'hFFEA;
`else
  localparam logic [15:0] EXT_3A = 16'h003A;
  localparam logic [15:0] EXT_2A = 16'h002A;
`endif

  typedef struct {
    int          cyc;
    logic [30:0] v;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  function automatic logic [30:0] mk(logic [3:0] ro, logic [3:0] ri, logic a, logic b,
                                     logic op, logic out, logic [15:0] ib,
                                     logic busy, logic done, logic err);
    return {ro, ri, a, b, op, out, ib, busy, done, err};
  endfunction

  function automatic void push_exp(int d, int c, logic [30:0] v);
    exp_t e;
    e.cyc = c;
    e.v   = v;
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endfunction

  // Expected states from LOAD_A onward. lim truncates the list for abort and reset cases.
  function automatic void push_op(int d, int k, int sel, logic [15:0] ib, int e, int lim);
    logic [3:0] oh;
    oh = 4'b0001 << sel;
    for (int i = 0; i < 4 + e && i < lim; i++) begin
      if (i == 0)
        push_exp(d, k + 1 + i, mk(oh, 4'b0, 1, 0, 0, 0, 16'h0, 1, 0, 0));
      else if (i == 1)
        push_exp(d, k + 1 + i, mk(4'b0, 4'b0, 0, 1, 0, 0, ib, 1, 0, 0));
      else if (i < 2 + e)
        push_exp(d, k + 1 + i, mk(4'b0, 4'b0, 0, 0, 1, 0, 16'h0, 1, 0, 0));
      else if (i == 2 + e)
        push_exp(d, k + 1 + i, mk(4'b0, oh, 0, 0, 0, 1, 16'h0, 1, 0, 0));
      else
        push_exp(d, k + 1 + i, mk(4'b0, 4'b0, 0, 0, 0, 0, 16'h0, 1, 1, 0));
    end
  endfunction

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [30:0] obs0, obs1;
  assign obs0 = {if0.reg_out_en, if0.reg_in_en, if0.alu_a_en, if0.alu_b_en, if0.alu_op_en,
                 if0.alu_out_en, if0.imm_bus, if0.busy, if0.done, if0.err};
  assign obs1 = {if1.reg_out_en, if1.reg_in_en, if1.alu_a_en, if1.alu_b_en, if1.alu_op_en,
                 if1.alu_out_en, if1.imm_bus, if1.busy, if1.done, if1.err};

  always @(negedge clk) begin
    if (mon_en && obs0 != 31'd0) begin
      n_cmp++;
      if (q0.size() == 0) begin
        n_bad++;
        $display("FAIL mon0 unexpected activity cyc=%0d got=%h required=idle", cyc, obs0);
      end else begin
        exp_t e;
        e = q0.pop_front();
        if (e.cyc != cyc || e.v != obs0) begin
          n_bad++;
          $display("FAIL mon0 cyc=%0d got=%h required=%h at cyc=%0d", cyc, obs0, e.v, e.cyc);
        end else begin
          $display("mon0 cyc=%0d outputs=%h ok", cyc, obs0);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en && obs1 != 31'd0) begin
      n_cmp++;
      if (q1.size() == 0) begin
        n_bad++;
        $display("FAIL mon1 unexpected activity cyc=%0d got=%h required=idle", cyc, obs1);
      end else begin
        exp_t e;
        e = q1.pop_front();
        if (e.cyc != cyc || e.v != obs1) begin
          n_bad++;
          $display("FAIL mon1 cyc=%0d got=%h required=%h at cyc=%0d", cyc, obs1, e.v, e.cyc);
        end else begin
          $display("mon1 cyc=%0d outputs=%h ok", cyc, obs1);
        end
      end
    end
  end

  initial begin
    int k;
    int guard;
    rst0 = 1'b1; rst1 = 1'b1;
    if0.start = 0; if0.abort = 0; if0.reg_sel = '0; if0.imm = '0;
    if1.start = 0; if1.abort = 0; if1.reg_sel = '0; if1.imm = '0;
    tick(3);
    n_cmp++;
    if (obs0 != 31'd0 || obs1 != 31'd0) begin
      n_bad++;
      $display("FAIL reset_state got0=%h got1=%h required=0", obs0, obs1);
    end
    rst0 = 1'b0; rst1 = 1'b0;
    mon_en = 1'b1;
    tick(1);

    // basic op; inputs change after capture and must not matter
    k = cyc; if0.start = 1; if0.reg_sel = 2; if0.imm = 6'h15;
    push_op(0, k, 2, 16'h0015, 1, 99);
    tick(1); if0.start = 0; if0.reg_sel = 3; if0.imm = 6'h3F;
    tick(8);

    // immediate extension, register 0
    k = cyc; if0.start = 1; if0.reg_sel = 0; if0.imm = 6'h3A;
    push_op(0, k, 0, EXT_3A, 1, 99);
    tick(1); if0.start = 0;
    tick(7);

    // out-of-range select
    k = cyc; if0.start = 1; if0.reg_sel = 5; if0.imm = 6'h01;
    push_exp(0, k + 1, mk(4'b0, 4'b0, 0, 0, 0, 0, 16'h0, 0, 0, 1));
    tick(1); if0.start = 0;
    tick(4);

    // abort during LOAD_B
    k = cyc; if0.start = 1; if0.reg_sel = 1; if0.imm = 6'h01;
    push_op(0, k, 1, 16'h0001, 1, 2);
    tick(1); if0.start = 0;
    tick(1); if0.abort = 1;
    tick(1); if0.abort = 0;
    tick(4);

    // start and abort together in IDLE
    if0.start = 1; if0.abort = 1; if0.reg_sel = 1;
    tick(1); if0.start = 0; if0.abort = 0;
    tick(4);

    // start held high: second op accepted in the first IDLE cycle after DONE
    k = cyc; if0.start = 1; if0.reg_sel = 3; if0.imm = 6'h2A;
    push_op(0, k, 3, EXT_2A, 1, 99);
    push_op(0, k + 6, 3, EXT_2A, 1, 99);
    tick(7); if0.start = 0;
    tick(8);

    // EXEC_CYCLES=3 with a start pulse during EXEC
    k = cyc; if1.start = 1; if1.reg_sel = 1; if1.imm = 6'h15;
    push_op(1, k, 1, 16'h0015, 3, 99);
    tick(1); if1.start = 0;
    tick(3); if1.start = 1; if1.reg_sel = 2;
    tick(1); if1.start = 0;
    tick(6);

    // two-cycle reset in the first EXEC cycle, then a normal op
    k = cyc; if1.start = 1; if1.reg_sel = 2; if1.imm = 6'h3A;
    push_op(1, k, 2, EXT_3A, 3, 3);
    tick(1); if1.start = 0;
    tick(2); rst1 = 1'b1;
    tick(2);
    n_cmp++;
    if (obs1 != 31'd0) begin
      n_bad++;
      $display("FAIL reset_mid_exec got=%h required=0", obs1);
    end
    rst1 = 1'b0;
    tick(1);
    k = cyc; if1.start = 1; if1.reg_sel = 0; if1.imm = 6'h01;
    push_op(1, k, 0, 16'h0001, 3, 99);
    tick(1); if1.start = 0;
    tick(9);

    guard = 0;
    while ((q0.size() != 0 || q1.size() != 0) && guard < 20) begin
      tick(1);
      guard++;
    end
    n_cmp++;
    if (q0.size() != 0) begin
      n_bad++;
      $display("FAIL drain0 got=%0d pending required=0", q0.size());
    end
    n_cmp++;
    if (q1.size() != 0) begin
      n_bad++;
      $display("FAIL drain1 got=%0d pending required=0", q1.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
